analysis_sequencer: RTL and testbench

Frame-level controller placed between the camera capture path, the frame buffer and the shape/colour processing block. On a user trigger it lets the camera fill the buffer for a configurable number of frames and freezes capture so the buffer is stable. It then holds the processing block's start level until a fresh done, with a watchdog, and publishes the latched colour/figure result. Optionally it re-arms continuously.

---
 rtl/analysis_pkg.sv | 34 +++
 rtl/analysis_sequencer_rise_detect.sv | 21 ++
 rtl/analysis_sequencer.sv | 121 ++++++++++++
 tb/tb_analysis_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/analysis_pkg.sv
// Shared state, result and code definitions for the analysis sequencer and its peers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package analysis_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        FREEZE  = 3'd2,
        RUN     = 3'd3,
        LATCH   = 3'd4,
        RELEASE = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] color;
        logic [1:0] figure;
    } result_t;

    localparam logic [1:0] COLOR_NONE   = 2'd0;
    localparam logic [1:0] COLOR_RED    = 2'd1;
    localparam logic [1:0] COLOR_GREEN  = 2'd2;
    localparam logic [1:0] COLOR_BLUE   = 2'd3;

    localparam logic [1:0] FIG_NONE     = 2'd0;
    localparam logic [1:0] FIG_TRIANGLE = 2'd1;
    localparam logic [1:0] FIG_CIRCLE   = 2'd2;
    localparam logic [1:0] FIG_SQUARE   = 2'd3;

    localparam int DEF_SKIP_FRAMES = 2;
    localparam int DEF_TO_W        = 20;
    localparam int DEF_REL_CYC     = 4;

endpackage

// File: rtl/analysis_sequencer_rise_detect.sv
// Registered rising-edge detector; preset forces the history bit high so a held level is not an edge.
// Latency: rise is combinational from d against the previous-cycle level.
// Backpressure: none.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic preset,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= 1'b0;
        else      q <= preset ? 1'b1 : d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/analysis_sequencer.sv
// Frame-level sequencer: arm capture, freeze buffer, run processing with watchdog, publish result.
// Latency: outputs registered from next-state; result one edge after the proc_done rising edge.
// Backpressure: none; triggers outside IDLE and frame_done outside ARM are dropped.
module analysis_sequencer
    import analysis_pkg::*;
#(
    parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
    parameter int TO_W        = DEF_TO_W,
    parameter int REL_CYC     = DEF_REL_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic       cont,
    input  logic       frame_done,
    output logic       cap_en,
    output logic       proc_start,
    input  logic       proc_done,
    input  logic [1:0] proc_color,
    input  logic [1:0] proc_figure,
    output logic [1:0] res_color,
    output logic [1:0] res_figure,
    output logic       res_valid,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [3:0]      SKIP_LAST = 4'(SKIP_FRAMES - 1);
    localparam logic [3:0]      REL_LAST  = 4'(REL_CYC - 1);
    localparam logic [TO_W-1:0] WD_MAX    = '1;
    // Leaving RUN one count early makes timeout_err rise as the watchdog hits all-ones.
    localparam logic [TO_W-1:0] WD_LAST   = {{(TO_W-1){1'b1}}, 1'b0};

    state_t          state, state_nxt;
    logic [3:0]      frame_cnt;
    logic [3:0]      rel_cnt;
    logic [TO_W-1:0] wd_cnt;
    logic            cont_q;
    logic            trig_rise;
    logic            done_rise;
    result_t         res;

    rise_detect u_trig_rise (
        .clk    (clk),
        .rst    (rst),
        .d      (trig),
        .preset (1'b0),
        .rise   (trig_rise)
    );

    // Presetting in FREEZE hides a done level left high by the previous run.
    rise_detect u_done_rise (
        .clk    (clk),
        .rst    (rst),
        .d      (proc_done),
        .preset (state == FREEZE),
        .rise   (done_rise)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig_rise) state_nxt = ARM;
            ARM:     if (frame_done && frame_cnt == SKIP_LAST) state_nxt = FREEZE;
            FREEZE:  state_nxt = RUN;
            RUN: begin
                if (done_rise)              state_nxt = LATCH;
                else if (wd_cnt == WD_LAST) state_nxt = RELEASE;
            end
            LATCH:   state_nxt = RELEASE;
            RELEASE: if (rel_cnt == REL_LAST) state_nxt = cont_q ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            frame_cnt   <= 4'd0;
            rel_cnt     <= 4'd0;
            wd_cnt      <= '0;
            cont_q      <= 1'b0;
            cap_en      <= 1'b1;
            proc_start  <= 1'b0;
            res         <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;

            // Counters idle at zero outside their own state, so every entry starts clean.
            if (state != ARM)   frame_cnt <= 4'd0;
            else if (frame_done) frame_cnt <= frame_cnt + 4'd1;

            if (state != RELEASE) rel_cnt <= 4'd0;
            else                  rel_cnt <= rel_cnt + 4'd1;

            if (state != RUN)          wd_cnt <= '0;
            else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;

            if (state == LATCH) cont_q <= cont;

            cap_en     <= (state_nxt == IDLE) || (state_nxt == ARM);
            proc_start <= (state_nxt == RUN);
            busy       <= (state_nxt != IDLE);
            res_valid  <= (state_nxt == LATCH);

            if (state_nxt == LATCH) res <= '{color: proc_color, figure: proc_figure};

            if (state == IDLE && trig_rise)
                timeout_err <= 1'b0;
            else if (state == RUN && state_nxt == RELEASE)
                timeout_err <= 1'b1;
        end
    end

    assign res_color  = res.color;
    assign res_figure = res.figure;

endmodule

// File: tb/tb_analysis_sequencer.sv
// Randomized bench for analysis_sequencer: transaction-level expectations from frame/done events.
module tb_analysis_sequencer;
    import analysis_pkg::*;

    localparam int SKIP = 2;
    localparam int TOW  = 8;
    localparam int REL  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig = 1'b0;
    logic       cont = 1'b0;
    logic       frame_done = 1'b0;
    logic       proc_done = 1'b0;
    logic [1:0] proc_color = 2'd0;
    logic [1:0] proc_figure = 2'd0;
    logic       cap_en, proc_start, res_valid, busy, timeout_err;
    logic [1:0] res_color, res_figure;

    always #5 clk = ~clk;

    analysis_sequencer #(.SKIP_FRAMES(SKIP), .TO_W(TOW), .REL_CYC(REL)) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .cont        (cont),
        .frame_done  (frame_done),
        .cap_en      (cap_en),
        .proc_start  (proc_start),
        .proc_done   (proc_done),
        .proc_color  (proc_color),
        .proc_figure (proc_figure),
        .res_color   (res_color),
        .res_figure  (res_figure),
        .res_valid   (res_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every accepted proc_done rise publishes exactly one result, in order.
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [1:0] last_c = 2'd0;
    logic [1:0] last_f = 2'd0;

    always @(negedge clk) begin
        if (rst && res_valid) got_q.push_back({res_color, res_figure});
    end

    // proc_start must stay low at least REL+1 cycles between runs.
    int low_len = 0;
    bit seen_high = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            seen_high = 1'b0;
            low_len   = 0;
        end else if (proc_start) begin
            if (seen_high && low_len > 0) check("ps_low_min", low_len >= REL + 1, 1);
            low_len   = 0;
            seen_high = 1'b1;
        end else begin
            low_len++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to_run(input bit do_trig, input bit stale);
        int gap;
        if (!stale) proc_done = 1'b0;
        if (do_trig) begin
            check("idle_cap", cap_en, 1);
            check("idle_busy", busy, 0);
            trig = 1'b1;
            tick();
            trig = 1'b0;
            check("arm_busy", busy, 1);
            check("arm_tmo_clr", timeout_err, 0);
        end
        for (int k = 0; k < SKIP; k++) begin
            gap = $urandom_range(0, 4);
            repeat (gap) begin
                trig = ($urandom_range(0, 2) == 0);
                tick();
                trig = 1'b0;
            end
            check("arm_cap", cap_en, 1);
            check("arm_ps", proc_start, 0);
            if (stale && k == SKIP - 1) proc_done = 1'b1;
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
        end
        check("frz_cap", cap_en, 0);
        check("frz_ps", proc_start, 0);
        check("frz_busy", busy, 1);
        tick();
        check("run_ps", proc_start, 1);
        check("run_cap", cap_en, 0);
    endtask

    task automatic run_once(input bit do_trig, input bit cont_v, input bit stale, input int fig);
        logic [1:0] c, f;
        int gap;
        cont = cont_v;
        go_to_run(do_trig, stale);
        if (stale) begin
            repeat (3) tick();
            proc_done = 1'b0;
            gap = $urandom_range(2, 100);
        end else begin
            gap = $urandom_range(1, 20);
        end
        repeat (gap) begin
            frame_done = ($urandom_range(0, 3) == 0);
            trig       = ($urandom_range(0, 3) == 0);
            tick();
            frame_done = 1'b0;
            trig       = 1'b0;
        end
        check("run_hold", proc_start, 1);
        c = 2'($urandom_range(0, 3));
        f = (fig >= 0) ? 2'(fig) : 2'($urandom_range(0, 3));
        proc_color  = c;
        proc_figure = f;
        proc_done   = 1'b1;
        exp_q.push_back({c, f});
        last_c = c;
        last_f = f;
        tick();
        check("lat_vld", res_valid, 1);
        check("lat_col", res_color, c);
        check("lat_fig", res_figure, f);
        check("lat_ps", proc_start, 0);
        proc_color  = 2'($urandom_range(0, 3));
        proc_figure = 2'($urandom_range(0, 3));
        proc_done   = 1'($urandom_range(0, 1));
        for (int i = 0; i < REL; i++) begin
            tick();
            check("rel_vld", res_valid, 0);
            check("rel_busy", busy, 1);
            check("rel_cap", cap_en, 0);
            check("rel_hold", {res_color, res_figure}, {c, f});
        end
        tick();
        check("end_busy", busy, cont_v);
        check("end_cap", cap_en, 1);
    endtask

    task automatic timeout_run();
        int n;
        cont = 1'b0;
        go_to_run(1'b1, 1'b0);
        n = 0;
        while (!timeout_err && n < 400) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, (1 << TOW) - 1);
        check("tmo_ps", proc_start, 0);
        check("tmo_busy", busy, 1);
        check("tmo_res", {res_color, res_figure}, {last_c, last_f});
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("tmo_rel_len", n, REL);
        check("tmo_sticky", timeout_err, 1);
        check("tmo_idle_cap", cap_en, 1);
    endtask

    task automatic reset_mid_run();
        go_to_run(1'b1, 1'b0);
        repeat (2) tick();
        #2;
        rst = 1'b0;
        #1;
        check("rst_cap", cap_en, 1);
        check("rst_ps", proc_start, 0);
        check("rst_busy", busy, 0);
        check("rst_res", {res_color, res_figure}, 0);
        check("rst_vld", res_valid, 0);
        check("rst_tmo", timeout_err, 0);
        last_c = 2'd0;
        last_f = 2'd0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rst_rel_busy", busy, 0);
        check("rst_rel_cap", cap_en, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_cap", cap_en, 1);
        check("reset_ps", proc_start, 0);
        check("reset_busy", busy, 0);
        check("reset_res", {res_color, res_figure}, 0);
        check("reset_vld", res_valid, 0);
        check("reset_tmo", timeout_err, 0);
        rst = 1'b1;
        tick();

        // Nominal single shot with the documented values.
        run_once(1'b1, 1'b0, 1'b0, FIG_SQUARE);
        repeat (3) run_once(1'b1, 1'b0, 1'($urandom_range(0, 1)), -1);
        run_once(1'b1, 1'b0, 1'b1, -1);

        timeout_run();
        run_once(1'b1, 1'b0, 1'b0, -1);

        // Continuous mode: only the first run is triggered.
        run_once(1'b1, 1'b1, 1'b0, FIG_TRIANGLE);
        run_once(1'b0, 1'b1, 1'($urandom_range(0, 1)), FIG_CIRCLE);
        run_once(1'b0, 1'b0, 1'b0, FIG_SQUARE);

        reset_mid_run();
        repeat (6) run_once(1'b1, 1'b0, 1'($urandom_range(0, 1)), -1);

        repeat (3) tick();
        check("n_results", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("result_seq", got_q[i], exp_q[i]);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
